// File: rtl/pip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pip_pkg
//  Description : Shared types for the pipeline sequencer: FSM states,
//                in-flight scoreboard slot, forward-select encodings and
//                the slot/source match helper.
//  Revision    : 1.0  initial release
// ============================================================================
package pip_pkg;

  // Scoreboard slots carry a fixed-width rd id; the sequencer's GPR_ID_W
  // parameter is expected to match this width.
  localparam int PIP_GPR_ID_W = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } pip_state_e;

  typedef struct packed {
    logic                    valid;
    logic                    wr_en;
    logic [PIP_GPR_ID_W-1:0] rd_id;
    logic                    is_load;
  } sb_slot_t;

  localparam logic [1:0] FWD_GPR = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_LS  = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // A source depends on a slot when it is actually read, is not x0, and the
  // slot holds a live instruction that writes the same register.
  function automatic logic sb_match(sb_slot_t s, logic en, logic [PIP_GPR_ID_W-1:0] id);
    return en && (id != '0) && s.valid && s.wr_en && (s.rd_id == id);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pip_ctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pip_ctl_if
//  Description : Pipeline-side signals of the sequencer. The slave modport
//                is the sequencer; the master modport is the pipeline.
//                Forward selects exist only with PIP_CTL_FWD_EN defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface pip_ctl_if #(
  parameter int GPR_ID_W = 5
) ();
  logic                i_ifu_valid;
  logic                i_idu_rs1_en;
  logic                i_idu_rs2_en;
  logic [GPR_ID_W-1:0] i_idu_rs1_id;
  logic [GPR_ID_W-1:0] i_idu_rs2_id;
  logic [GPR_ID_W-1:0] i_idu_rd_id;
  logic                i_idu_reg_wr_en;
  logic                i_idu_is_load;
  logic                i_exu_jmp_en;
  logic                i_exu_end;
  logic                i_lsu_ready;
  logic                o_pc_we;
  logic                o_i2d_valid;
  logic                o_i2e_valid;
  logic                o_e2l_valid;
  logic                o_l2w_valid;
  logic                o_stall;
  logic                o_flush;
  logic                o_halt;
`ifdef PIP_CTL_FWD_EN
  logic [1:0]          o_rs1_fwd_sel;
  logic [1:0]          o_rs2_fwd_sel;
`endif

  modport master (
    output i_ifu_valid, i_idu_rs1_en, i_idu_rs2_en, i_idu_rs1_id, i_idu_rs2_id,
           i_idu_rd_id, i_idu_reg_wr_en, i_idu_is_load, i_exu_jmp_en,
           i_exu_end, i_lsu_ready,
`ifdef PIP_CTL_FWD_EN
    input  o_rs1_fwd_sel, o_rs2_fwd_sel,
`endif
    input  o_pc_we, o_i2d_valid, o_i2e_valid, o_e2l_valid, o_l2w_valid,
           o_stall, o_flush, o_halt
  );

  modport slave (
    input  i_ifu_valid, i_idu_rs1_en, i_idu_rs2_en, i_idu_rs1_id, i_idu_rs2_id,
           i_idu_rd_id, i_idu_reg_wr_en, i_idu_is_load, i_exu_jmp_en,
           i_exu_end, i_lsu_ready,
`ifdef PIP_CTL_FWD_EN
    output o_rs1_fwd_sel, o_rs2_fwd_sel,
`endif
    output o_pc_we, o_i2d_valid, o_i2e_valid, o_e2l_valid, o_l2w_valid,
           o_stall, o_flush, o_halt
  );
endinterface
`default_nettype wire

// File: rtl/pip_hzd.sv
`default_nettype none
// ============================================================================
//  Module      : pip_hzd
//  Description : Combinational compare of the ID sources against the EX, LS
//                and WB scoreboard slots. Without PIP_CTL_FWD_EN any match
//                stalls; with it, only load-use in EX stalls and the
//                youngest matching slot is reported as forward source.
//  Revision    : 1.0  initial release
// ============================================================================
module pip_hzd
  import pip_pkg::*;
(
  input  logic                    i2d_valid_i,
  input  logic                    rs1_en_i,
  input  logic [PIP_GPR_ID_W-1:0] rs1_id_i,
  input  logic                    rs2_en_i,
  input  logic [PIP_GPR_ID_W-1:0] rs2_id_i,
  input  sb_slot_t                ex_i,
  input  sb_slot_t                ls_i,
  input  sb_slot_t                wb_i,
`ifdef PIP_CTL_FWD_EN
  output logic [1:0]              rs1_fwd_sel_o,
  output logic [1:0]              rs2_fwd_sel_o,
`endif
  output logic                    hazard_o
);

  // Per-source match vectors, bit order {WB, LS, EX}.
  logic [2:0] w_m1;
  logic [2:0] w_m2;
  logic       w_unused;

  assign w_m1 = {sb_match(wb_i, rs1_en_i, rs1_id_i),
                 sb_match(ls_i, rs1_en_i, rs1_id_i),
                 sb_match(ex_i, rs1_en_i, rs1_id_i)};
  assign w_m2 = {sb_match(wb_i, rs2_en_i, rs2_id_i),
                 sb_match(ls_i, rs2_en_i, rs2_id_i),
                 sb_match(ex_i, rs2_en_i, rs2_id_i)};

`ifdef PIP_CTL_FWD_EN
  // Youngest producer wins: EX, then LS, then WB.
  function automatic logic [1:0] pick(logic [2:0] m);
    if (m[0]) return FWD_EX;
    if (m[1]) return FWD_LS;
    if (m[2]) return FWD_WB;
    return FWD_GPR;
  endfunction

  assign rs1_fwd_sel_o = pick(w_m1);
  assign rs2_fwd_sel_o = pick(w_m2);
  // Load data is not available until LS completes, so a load in EX stalls.
  assign hazard_o      = i2d_valid_i & ex_i.is_load & (w_m1[0] | w_m2[0]);
  assign w_unused      = &{1'b0, ls_i.is_load, wb_i.is_load};
`else
  // No bypass network: wait until the producer has left WB.
  assign hazard_o      = i2d_valid_i & ((|w_m1) | (|w_m2));
  assign w_unused      = &{1'b0, ex_i.is_load, ls_i.is_load, wb_i.is_load};
`endif

endmodule
`default_nettype wire

// File: rtl/pip_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : pip_ctl
//  Description : 5-stage pipeline sequencer. Owns the stage valid bits and
//                an in-flight rd scoreboard; stalls on RAW hazards, squashes
//                wrong-path fetches on EXU jumps, freezes on LSU
//                backpressure, drains and halts on EXU end/ebreak.
//                Optional build macro: PIP_CTL_FWD_EN (forward selects,
//                load-use-only stalls).
//  Revision    : 1.0  initial release
// ============================================================================
module pip_ctl
  import pip_pkg::*;
#(
  parameter int GPR_ID_W  = PIP_GPR_ID_W,
  parameter int DRAIN_CYC = 2
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_rst,
  pip_ctl_if.slave    bus
);

  localparam int CNT_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);

  pip_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             i2d_q, i2d_d;
  // Slot valid bits double as the i2e / e2l / l2w stage valids.
  sb_slot_t         ex_q, ex_d, ls_q, ls_d, wb_q, wb_d;
  sb_slot_t         w_ex_new;
  logic             w_hazard;
  logic             w_pc_we, w_stall, w_flush;

  pip_hzd u_hzd (
    .i2d_valid_i   (i2d_q),
    .rs1_en_i      (bus.i_idu_rs1_en),
    .rs1_id_i      (bus.i_idu_rs1_id),
    .rs2_en_i      (bus.i_idu_rs2_en),
    .rs2_id_i      (bus.i_idu_rs2_id),
    .ex_i          (ex_q),
    .ls_i          (ls_q),
    .wb_i          (wb_q),
`ifdef PIP_CTL_FWD_EN
    .rs1_fwd_sel_o (bus.o_rs1_fwd_sel),
    .rs2_fwd_sel_o (bus.o_rs2_fwd_sel),
`endif
    .hazard_o      (w_hazard)
  );

  // Next state of FSM, valids and scoreboard, in priority order.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    i2d_d    = i2d_q;
    ex_d     = ex_q;
    ls_d     = ls_q;
    wb_d     = wb_q;
    w_pc_we  = 1'b0;
    w_stall  = 1'b0;
    w_flush  = 1'b0;
    w_ex_new = '{valid:   i2d_q,
                 wr_en:   bus.i_idu_reg_wr_en,
                 rd_id:   bus.i_idu_rd_id[GPR_ID_W-1:0],
                 is_load: bus.i_idu_is_load};

    unique case (state_q)
      ST_RUN: begin
        if (ex_q.valid && bus.i_exu_end) begin
          // Younger instructions are wrong-path once end retires.
          state_d = ST_DRAIN;
          cnt_d   = CNT_W'(DRAIN_CYC);
          i2d_d   = 1'b0;
          ex_d    = '0;
          if (bus.i_lsu_ready) begin
            ls_d = ex_q;
            wb_d = ls_q;
          end
        end else if (!bus.i_lsu_ready) begin
          // Freeze: everything holds; a jump in EX re-asserts next cycle.
        end else if (ex_q.valid && bus.i_exu_jmp_en) begin
          w_flush = 1'b1;
          w_pc_we = 1'b1;
          i2d_d   = 1'b0;
          ex_d    = '0;
          ls_d    = ex_q;
          wb_d    = ls_q;
        end else if (w_hazard) begin
          w_stall = 1'b1;
          ex_d    = '0;
          ls_d    = ex_q;
          wb_d    = ls_q;
        end else begin
          w_pc_we = 1'b1;
          i2d_d   = bus.i_ifu_valid;
          ex_d    = w_ex_new;
          ls_d    = ex_q;
          wb_d    = ls_q;
        end
      end
      ST_DRAIN: begin
        i2d_d = 1'b0;
        ex_d  = '0;
        if (cnt_q == '0) begin
          state_d = ST_HALT;
          ls_d    = '0;
          wb_d    = '0;
        end else if (bus.i_lsu_ready) begin
          cnt_d = cnt_q - CNT_W'(1);
          ls_d  = ex_q;
          wb_d  = ls_q;
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_HALT;
            ls_d    = '0;
            wb_d    = '0;
          end
        end
      end
      default: begin
        state_d = ST_HALT;
        i2d_d   = 1'b0;
        ex_d    = '0;
        ls_d    = '0;
        wb_d    = '0;
      end
    endcase
  end

  // State, valid and scoreboard registers with synchronous reset.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      i2d_q   <= 1'b0;
      ex_q    <= '0;
      ls_q    <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i2d_q   <= i2d_d;
      ex_q    <= ex_d;
      ls_q    <= ls_d;
      wb_q    <= wb_d;
    end
  end

  assign bus.o_pc_we     = w_pc_we;
  assign bus.o_stall     = w_stall;
  assign bus.o_flush     = w_flush;
  assign bus.o_i2d_valid = i2d_q;
  assign bus.o_i2e_valid = ex_q.valid;
  assign bus.o_e2l_valid = ls_q.valid;
  assign bus.o_l2w_valid = wb_q.valid;
  assign bus.o_halt      = (state_q == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_pip_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pip_ctl
//  Description : Directed self-checking bench for pip_ctl: reset mid-stream,
//                RAW stall, x0, jump over hazard, LSU freeze, end/halt.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pip_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pip_ctl_if #(.GPR_ID_W(5)) bus ();

  pip_ctl #(.GPR_ID_W(5), .DRAIN_CYC(2)) dut (
    .i_sys_clk (clk),
    .i_sys_rst (rst),
    .bus       (bus)
  );

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [3:0] vld();
    return {bus.o_i2d_valid, bus.o_i2e_valid, bus.o_e2l_valid, bus.o_l2w_valid};
  endfunction

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idu(input logic r1e, input logic [4:0] r1, input logic r2e,
                     input logic [4:0] r2, input logic wr, input logic [4:0] rd,
                     input logic ld);
    bus.i_idu_rs1_en = r1e; bus.i_idu_rs1_id = r1;
    bus.i_idu_rs2_en = r2e; bus.i_idu_rs2_id = r2;
    bus.i_idu_reg_wr_en = wr; bus.i_idu_rd_id = rd; bus.i_idu_is_load = ld;
  endtask

  task automatic idle_in();
    idu(0, 0, 0, 0, 0, 0, 0);
    bus.i_ifu_valid  = 1'b0;
    bus.i_exu_jmp_en = 1'b0;
    bus.i_exu_end    = 1'b0;
    bus.i_lsu_ready  = 1'b1;
  endtask

  task automatic empty_pipe();
    idle_in();
    for (int i = 0; i < 4; i++) nxt();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset, then reset mid-stream ----------------
    idle_in();
    rst = 1'b1;
    nxt(); nxt();
    rst = 1'b0;
    bus.i_ifu_valid = 1'b1;
    @(negedge clk);
    chk("rst_vld",   8'(vld()), 8'h0);
    chk("rst_halt",  8'(bus.o_halt), 8'h0);
    chk("rst_stall", 8'(bus.o_stall), 8'h0);
    chk("rst_flush", 8'(bus.o_flush), 8'h0);
    chk("rst_pcwe",  8'(bus.o_pc_we), 8'h1);
    nxt(); nxt(); nxt();
    bus.i_ifu_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_vld", 8'(vld()), 8'b1110);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld",  8'(vld()), 8'h0);
    chk("mid_rst_halt", 8'(bus.o_halt), 8'h0);
    bus.i_ifu_valid = 1'b1;
    nxt();
    @(negedge clk);
    chk("post_rst_run", 8'(vld()), 8'b1000);
    empty_pipe();

    // ---------------- RAW on x5 ----------------
    bus.i_ifu_valid = 1'b1;
    nxt();
    idu(0, 0, 0, 0, 1, 5, 0);
    @(negedge clk);
    chk("raw_prod_nostall", 8'(bus.o_stall), 8'h0);
    nxt();
    idu(1, 5, 0, 0, 0, 0, 0);
    bus.i_ifu_valid = 1'b0;
    @(negedge clk);
`ifdef PIP_CTL_FWD_EN
    chk("raw_fwd_nostall", 8'(bus.o_stall), 8'h0);
    chk("raw_fwd_sel",     8'(bus.o_rs1_fwd_sel), 8'h1);
`else
    chk("raw_stall1", 8'(bus.o_stall), 8'h1);
    chk("raw_pcwe1",  8'(bus.o_pc_we), 8'h0);
    chk("raw_vld1",   8'(vld()), 8'b1100);
    nxt();
    @(negedge clk);
    chk("raw_stall2", 8'(bus.o_stall), 8'h1);
    chk("raw_vld2",   8'(vld()), 8'b1010);
    nxt();
    @(negedge clk);
    chk("raw_stall3", 8'(bus.o_stall), 8'h1);
    chk("raw_vld3",   8'(vld()), 8'b1001);
    nxt();
    @(negedge clk);
    chk("raw_release", 8'(bus.o_stall), 8'h0);
    chk("raw_vld4",    8'(vld()), 8'b1000);
    nxt();
    idu(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("raw_issue", 8'(vld()), 8'b0100);
`endif
    empty_pipe();

    // ---------------- x0 never hazards ----------------
    bus.i_ifu_valid = 1'b1;
    nxt();
    idu(0, 0, 0, 0, 1, 0, 0);
    nxt();
    idu(1, 0, 1, 0, 0, 0, 0);
    bus.i_ifu_valid = 1'b0;
    @(negedge clk);
    chk("x0_nostall", 8'(bus.o_stall), 8'h0);
    nxt();
    idu(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("x0_vld", 8'(vld()), 8'b0110);
    empty_pipe();

    // ---------------- jump in EX over a hazarding ID ----------------
    bus.i_ifu_valid = 1'b1;
    nxt();
    idu(0, 0, 0, 0, 1, 5, 0);
    nxt();
    idu(1, 5, 0, 0, 0, 0, 0);
    bus.i_exu_jmp_en = 1'b1;
    @(negedge clk);
    chk("jmp_flush", 8'(bus.o_flush), 8'h1);
    chk("jmp_pcwe",  8'(bus.o_pc_we), 8'h1);
    chk("jmp_stall", 8'(bus.o_stall), 8'h0);
    nxt();
    idle_in();
    @(negedge clk);
    chk("jmp_vld",    8'(vld()), 8'b0010);
    chk("jmp_flush0", 8'(bus.o_flush), 8'h0);
    chk("jmp_stall0", 8'(bus.o_stall), 8'h0);
    empty_pipe();

    // ---------------- LSU freeze while EX holds a jump ----------------
    bus.i_ifu_valid = 1'b1;
    nxt(); nxt(); nxt();
    bus.i_exu_jmp_en = 1'b1;
    bus.i_lsu_ready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("frz_vld%0d", i),   8'(vld()), 8'b1110);
      chk($sformatf("frz_flush%0d", i), 8'(bus.o_flush), 8'h0);
      chk($sformatf("frz_pcwe%0d", i),  8'(bus.o_pc_we), 8'h0);
      nxt();
    end
    bus.i_lsu_ready = 1'b1;
    @(negedge clk);
    chk("frz_rel_flush", 8'(bus.o_flush), 8'h1);
    chk("frz_rel_pcwe",  8'(bus.o_pc_we), 8'h1);
    nxt();
    bus.i_exu_jmp_en = 1'b0;
    bus.i_ifu_valid  = 1'b0;
    @(negedge clk);
    chk("frz_after_vld", 8'(vld()), 8'b0011);
    empty_pipe();

    // ---------------- end event, drain, halt ----------------
    bus.i_ifu_valid = 1'b1;
    nxt(); nxt(); nxt();
    @(negedge clk);
    chk("end_pre_vld", 8'(vld()), 8'b1110);
    nxt();
    bus.i_exu_end = 1'b1;
    @(negedge clk);
    chk("end_vld0",  8'(vld()), 8'b1111);
    chk("end_pcwe0", 8'(bus.o_pc_we), 8'h0);
    chk("end_halt0", 8'(bus.o_halt), 8'h0);
    nxt();
    bus.i_exu_end = 1'b0;
    @(negedge clk);
    chk("end_vld1",  8'(vld()), 8'b0011);
    chk("end_halt1", 8'(bus.o_halt), 8'h0);
    nxt();
    @(negedge clk);
    chk("end_vld2",  8'(vld()), 8'b0001);
    chk("end_halt2", 8'(bus.o_halt), 8'h0);
    nxt();
    @(negedge clk);
    chk("end_vld3",  8'(vld()), 8'b0000);
    chk("end_halt3", 8'(bus.o_halt), 8'h1);
    for (int i = 0; i < 3; i++) begin
      nxt();
      @(negedge clk);
      chk($sformatf("halt_sticky%0d", i), 8'(bus.o_halt), 8'h1);
      chk($sformatf("halt_vld%0d", i),    8'(vld()), 8'h0);
      chk($sformatf("halt_pcwe%0d", i),   8'(bus.o_pc_we), 8'h0);
    end
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("halt_rst", 8'(bus.o_halt), 8'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pip_ctl.md
Name: pip_ctl

Overview:
- Central sequencer for the 5-stage core pipeline (IFU, IDU, EXU, LSU, WBU).
- Owns the per-stage valid bits, including the i2e valid that qualifies every EXU output.
- Tracks in-flight destination registers, stalls on RAW hazards, flushes wrong-path instructions on EXU jumps, freezes on LSU backpressure.
- Drains and halts on the EXU end/ebreak event.

Parameters:
- GPR_ID_W, 5, width of a GPR index.
- DRAIN_CYC, 2, cycles to let LSU/WBU retire after an end event before halting.

Ports:
- i_sys_clk  in  1  clock; all state updates on the rising edge.
- i_sys_rst  in  1  reset, synchronous, active-high.
- i_ifu_valid  in  1  IFU presents a fetched instruction.
- i_idu_rs1_en / i_idu_rs2_en  in  1  decoded instruction reads rs1 / rs2.
- i_idu_rs1_id / i_idu_rs2_id  in  GPR_ID_W  source register ids.
- i_idu_rd_id  in  GPR_ID_W  destination register id.
- i_idu_reg_wr_en  in  1  decoded instruction writes rd.
- i_idu_is_load  in  1  decoded instruction is a load.
- i_exu_jmp_en  in  1  EXU taken jump or branch.
- i_exu_end  in  1  EXU end/ebreak (jump type E).
- i_lsu_ready  in  1  LSU can accept or complete this cycle.
- o_pc_we  out  1  IFU may advance PC / load the jump target.
- o_i2d_valid, o_i2e_valid, o_e2l_valid, o_l2w_valid  out  1  stage valid bits.
- o_stall  out  1  hazard stall: IF/ID held, bubble into EX.
- o_flush  out  1  wrong-path squash this cycle.
- o_halt  out  1  core halted (sticky).

Behaviour:
- Reset:
  - All valid bits, o_stall, o_flush and o_halt are 0.
  - Scoreboard is cleared and the FSM goes to RUN.
  - Reset asserted mid-operation discards everything on the next edge.
- FSM states: RUN, DRAIN, HALT.
  - RUN to DRAIN when o_i2e_valid and i_exu_end are both 1. The counter loads DRAIN_CYC.
  - DRAIN: i2d/i2e valid are forced to 0. LS and WB continue to shift. The counter decrements each cycle i_lsu_ready is 1.
  - DRAIN to HALT when the counter reaches 0.
  - HALT: all valids are 0 and o_pc_we is 0. o_halt stays 1 until reset.
- Scoreboard:
  - Holds {valid, wr_en, rd_id, is_load} for the EX, LS and WB slots.
  - Shifts in step with the valid bits.
- Hazard:
  - Raised when o_i2d_valid is 1, rsX_en is 1, rsX_id is nonzero, and rsX_id equals rd_id of any slot with valid=1 and wr_en=1.
  - rd equal to 0 never hazards.
- Priority, highest first: reset > DRAIN/HALT > LSU freeze > flush > stall > advance.
  - LSU freeze (i_lsu_ready=0): every stage register and the scoreboard hold; o_pc_we=0. A jump held in EX re-asserts, so the flush fires on the first unfrozen cycle.
  - Flush (o_i2e_valid=1 and i_exu_jmp_en=1): next cycle o_i2d_valid=0 and o_i2e_valid=0. EX moves to LS normally. o_pc_we=1 to take the target. o_flush=1 for exactly that cycle. Flush overrides a concurrent hazard stall.
  - Stall: IF and ID hold; o_pc_we=0. Next cycle o_i2e_valid=0 and the EX scoreboard slot is cleared. LS and WB advance.
  - Advance: each valid moves one stage per cycle. o_i2d_valid takes i_ifu_valid. Latency is 1 cycle per stage.
- o_stall and o_flush are combinational from current state; all valids are registered.

Optional Feature:
- Macro: PIP_CTL_FWD_EN.
- When defined:
  - Adds outputs o_rs1_fwd_sel and o_rs2_fwd_sel, 2 bits each: 0 = GPR file, 1 = EX, 2 = LS, 3 = WB.
  - When several slots match, the youngest match wins.
  - Hazard reduces to load-use only: an EX slot with is_load=1 and a matching rd gives a 1-cycle stall.
- When undefined: the ports are absent and every match stalls until the producer leaves WB.

Decomposition:
- Shared package pip_pkg holds:
  - FSM state enum (RUN, DRAIN, HALT).
  - Scoreboard slot struct.
  - fwd_sel encoding constants.
- One sub-module, pip_hzd: combinational hazard and forward-select compare of the ID sources against the 3 scoreboard slots.

Test Plan:
- Reset mid-stream: after 3 instructions are issued, assert i_sys_rst for 1 cycle → next cycle all valids 0, o_halt 0, state RUN.
- RAW hazard: i_idu_rd_id=5 write, then next instruction rs1=5 (FWD off) → o_stall=1 for 3 cycles, with a bubble (o_i2e_valid=0) each cycle. With FWD on: no stall, o_rs1_fwd_sel=1.
- rd=x0: write x0 then read x0 → o_stall never 1.
- Jump with concurrent hazard: i_exu_jmp_en=1 while ID is stalled → o_flush=1 for 1 cycle, o_pc_we=1. Next cycle o_i2d_valid=0 and o_i2e_valid=0, o_stall=0.
- LSU freeze during jump: i_lsu_ready=0 for 4 cycles while EX holds a jump → all valids hold, o_flush=0. The cycle i_lsu_ready rises → o_flush=1.
- End event: i_exu_end with DRAIN_CYC=2 and LSU always ready → o_l2w_valid retires the older instructions, o_halt=1 at cycle 3 and stays 1 under further i_ifu_valid=1.
